// File: rtl/fetch_pkg.sv
// Shared widths, the buffered-fetch entry type and the idle instruction for the fetch front end.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 16;
    localparam int FETCH_INSTR_W = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_sync_fifo.sv
// Small synchronous FIFO with clear; head is the stored word, count/full/empty are registered.
// A push into a full FIFO that is not also popping is dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: contents are only observed through a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push && !(rst || clear)) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order imem requests, returned words buffered with their PCs.
// Response to decode valid one cycle after the memory response; PC stalls unless a request is accepted.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               fetch_stall_o,
    input  logic               flush_i,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [ADDR_W-1:0]  imem_req_addr_o,
    input  logic               imem_rsp_valid_i,
    input  logic [INSTR_W-1:0] imem_rsp_data_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] pend_head;
    logic              pend_full;
    logic              pend_empty;
    logic [CW-1:0]     pend_count;
    logic [EW-1:0]     iq_head;
    logic              iq_full;
    logic              iq_empty;
    logic [CW-1:0]     iq_count;
    logic [CW-1:0]     discard_cnt;
    logic [CW:0]       occupancy;

    logic req_fire;
    logic rsp_take;
    logic rsp_keep;
    logic iq_pop;

    // Every issued request holds one credit until its word leaves iq or its discard is retired.
    assign occupancy = {1'b0, pend_count} + {1'b0, iq_count} + {1'b0, discard_cnt};

    assign imem_req_valid_o = !rst && !flush_i && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr_o  = pc_i;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign fetch_stall_o    = rst || (!req_fire && !flush_i);

    assign rsp_take = imem_rsp_valid_i && !rst;
    assign rsp_keep = rsp_take && !flush_i && (discard_cnt == '0);

    assign instr_valid_o = !iq_empty && !flush_i;
    assign iq_pop        = instr_valid_o && instr_ready_i;
    assign instr_o       = iq_empty ? INSTR_W'(NOP_INSTR) : iq_head[INSTR_W-1:0];
    assign instr_pc_o    = iq_empty ? '0 : iq_head[EW-1 -: ADDR_W];

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pend (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (req_fire),
        .push_data (pc_i),
        .pop       (rsp_keep),
        .head      (pend_head),
        .full      (pend_full),
        .empty     (pend_empty),
        .count     (pend_count)
    );

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_iq (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (rsp_keep),
        .push_data ({pend_head, imem_rsp_data_i}),
        .pop       (iq_pop),
        .head      (iq_head),
        .full      (iq_full),
        .empty     (iq_empty),
        .count     (iq_count)
    );

    // On redirect every still-pending request becomes a word the memory still owes us.
    always_ff @(posedge clk) begin
        if (rst) begin
            discard_cnt <= '0;
        end else if (flush_i) begin
            discard_cnt <= discard_cnt + pend_count - CW'(rsp_take);
        end else if (rsp_take && (discard_cnt != '0)) begin
            discard_cnt <= discard_cnt - CW'(1);
        end
    end

    a_iq_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && iq_full && !iq_pop));
    a_pend_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_fire && pend_full));
    a_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && pend_empty));
    a_credit: assert property (@(posedge clk) disable iff (rst)
        occupancy <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: queue-based reference model, emulated program_counter and in-order memory.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = FETCH_ADDR_W;
    localparam int IW    = FETCH_INSTR_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_i;
    logic          fetch_stall_o;
    logic          flush_i;
    logic          imem_req_valid_o;
    logic          imem_req_ready_i;
    logic [AW-1:0] imem_req_addr_o;
    logic          imem_rsp_valid_i;
    logic [IW-1:0] imem_rsp_data_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [IW-1:0] instr_o;
    logic [AW-1:0] instr_pc_o;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .fetch_stall_o    (fetch_stall_o),
        .flush_i          (flush_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: what the fetch unit owes, holds, and what memory has accepted.
    logic [AW-1:0] pend_q[$];
    fetch_entry_t  iq_q[$];
    int            disc;
    logic [31:0]   mem_q[$];
    logic [15:0]   seq;
    logic [AW-1:0] pc_model;
    bit            after_reset;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input int p_rdy, input int p_rsp, input int p_drdy, input int p_flush);
        int            occ;
        bit            e_req;
        bit            fire;
        bit            e_stall;
        bit            e_iv;
        bit            rsp;
        logic [AW-1:0] p;

        rst              = r;
        imem_req_ready_i = ($urandom_range(99) < p_rdy);
        flush_i          = !r && ($urandom_range(99) < p_flush);
        instr_ready_i    = ($urandom_range(99) < p_drdy);
        if (r) begin
            imem_rsp_valid_i = $urandom_range(1) == 1;
            imem_rsp_data_i  = $urandom;
        end else if (mem_q.size() > 0 && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_q[0];
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end
        pc_i = pc_model;
        #4;

        occ     = pend_q.size() + iq_q.size() + disc;
        e_req   = !r && !flush_i && (occ < DEPTH);
        fire    = e_req && imem_req_ready_i;
        e_stall = r || (!fire && !flush_i);
        e_iv    = (iq_q.size() > 0) && !flush_i;

        chk("req_valid", 64'(imem_req_valid_o), 64'(e_req));
        chk("req_addr", 64'(imem_req_addr_o), 64'(pc_i));
        chk("stall", 64'(fetch_stall_o), 64'(e_stall));
        chk("instr_valid", 64'(instr_valid_o), 64'(e_iv));
        if (e_iv) begin
            chk("instr", 64'(instr_o), 64'(iq_q[0].instr));
            chk("instr_pc", 64'(instr_pc_o), 64'(iq_q[0].pc));
        end
        if (after_reset) begin
            chk("rst_instr", 64'(instr_o), 64'(NOP_INSTR));
            chk("rst_instr_pc", 64'(instr_pc_o), 64'(0));
        end

        rsp = imem_rsp_valid_i;
        if (r) begin
            pend_q.delete();
            iq_q.delete();
            mem_q.delete();
            disc     = 0;
            pc_model = '0;
        end else begin
            if (flush_i) begin
                disc = disc + pend_q.size() - int'(rsp);
                pend_q.delete();
                iq_q.delete();
                pc_model = ($urandom_range(7) == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFC);
            end else begin
                if (e_iv && instr_ready_i) void'(iq_q.pop_front());
                if (rsp) begin
                    if (disc > 0) begin
                        disc--;
                    end else begin
                        p = pend_q.pop_front();
                        iq_q.push_back('{pc: p, instr: imem_rsp_data_i});
                    end
                end
                if (fire) pend_q.push_back(pc_i);
                if (!e_stall) pc_model = pc_model + 16'd4;
            end
            if (rsp) void'(mem_q.pop_front());
            if (fire) begin
                mem_q.push_back({seq, pc_i});
                seq = seq + 16'd1;
            end
        end
        after_reset = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cfg [5][5];
        cfg = '{'{40, 100, 100, 100, 0},
                '{400, 70, 60, 80, 8},
                '{300, 100, 100, 20, 5},
                '{300, 50, 90, 100, 15},
                '{200, 100, 100, 100, 25}};

        rst              = 1'b1;
        pc_i             = '0;
        flush_i          = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        instr_ready_i    = 1'b0;
        disc             = 0;
        seq              = 16'd0;
        pc_model         = '0;
        after_reset      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int ph = 0; ph < 5; ph++) begin
            step(1'b1, 100, 100, 100, 0);
            for (int c = 0; c < cfg[ph][0]; c++) begin
                step(($urandom_range(199) == 0), cfg[ph][1], cfg[ph][2], cfg[ph][3], cfg[ph][4]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
